// File: rtl/joy_conditioner_pkg.sv
// Shared constants for the joystick conditioner: bit positions inside a
// player byte, player byte offsets and the opposing-direction filter.
package joy_conditioner_pkg;

   localparam int UP     = 7;
   localparam int DOWN   = 6;
   localparam int LEFT   = 5;
   localparam int RIGHT  = 4;
   localparam int FIRE1  = 3;
   localparam int FIRE2  = 2;
   localparam int FIRE3  = 1;
   localparam int START  = 0;

   localparam int P1_OFS      = 0;
   localparam int P2_OFS      = 8;
   localparam int NUM_PLAYERS = 2;
   localparam int NUM_BITS    = 16;

   // Pressing both directions of an axis cancels that axis entirely.
   function automatic logic [7:0] neutralize(input logic [7:0] pressed);
      logic [7:0] result;
      result = pressed;
      if (pressed[UP] && pressed[DOWN]) begin
         result[UP]   = 1'b0;
         result[DOWN] = 1'b0;
      end
      if (pressed[LEFT] && pressed[RIGHT]) begin
         result[LEFT]  = 1'b0;
         result[RIGHT] = 1'b0;
      end
      return result;
   endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a tick-driven debounce
// counter; the output is the accepted (still active-low) level.
module joy_debounce_bit
   import joy_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw_n,
   output logic stable_n
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

   logic       sync1_reg;
   logic       sync2_reg;
   logic       stable_reg;
   logic [7:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg  <= 1'b1;
         sync2_reg  <= 1'b1;
         stable_reg <= 1'b1;
         cnt_reg    <= 8'd0;
      end else begin
         sync1_reg <= raw_n;
         sync2_reg <= sync1_reg;
         if (tick) begin
            // Any tick that sees the accepted level again restarts the count.
            if (sync2_reg == stable_reg) begin
               cnt_reg <= 8'd0;
            end else if (cnt_reg == CNT_LAST) begin
               stable_reg <= sync2_reg;
               cnt_reg    <= 8'd0;
            end else begin
               cnt_reg <= cnt_reg + 8'd1;
            end
         end
      end
   end

   assign stable_n = stable_reg;

endmodule

// File: rtl/joy_conditioner.sv
// Two-player joystick conditioner: debounce, opposing-direction filter,
// per-player autofire and a single-entry change-event buffer.
module joy_conditioner
   import joy_conditioner_pkg::*;
#(
   parameter int TICK_DIV       = 1024,
   parameter int DEBOUNCE_TICKS = 8,
   parameter int AUTOFIRE_TICKS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] joy_raw_n,
   input  logic [1:0]  autofire_en,
   output logic [7:0]  joy1,
   output logic [7:0]  joy2,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [15:0] evt_data,
   output logic        evt_overrun
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [7:0]    AF_LAST   = 8'(AUTOFIRE_TICKS - 1);

   logic [TW-1:0] tick_cnt_reg;
   logic          tick;
   logic [15:0]   stable_n;
   logic [15:0]   pressed;
   logic [1:0]    af_en_reg;
   logic [15:0]   cond_word;
   logic [15:0]   prev_word_reg;
   logic          change_evt;

   assign tick = (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_reg <= '0;
      end else if (tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
         joy_debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
         ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .raw_n   (joy_raw_n[gi]),
            .stable_n(stable_n[gi])
         );
      end
   endgenerate

   assign pressed = ~stable_n;

   // Enable changes only take effect on tick boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         af_en_reg <= 2'b00;
      end else if (tick) begin
         af_en_reg <= autofire_en;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
         logic [7:0] af_cnt_reg;
         logic       af_on_reg;
         logic       fire_pressed;
         logic [7:0] player_byte;

         assign fire_pressed = pressed[gi*8 + FIRE1];

         // The phase restarts "on" whenever fire1 is released or autofire is off.
         always_ff @(posedge clk) begin
            if (reset) begin
               af_cnt_reg <= 8'd0;
               af_on_reg  <= 1'b1;
            end else if (!fire_pressed || !af_en_reg[gi]) begin
               af_cnt_reg <= 8'd0;
               af_on_reg  <= 1'b1;
            end else if (tick) begin
               if (af_cnt_reg == AF_LAST) begin
                  af_cnt_reg <= 8'd0;
                  af_on_reg  <= ~af_on_reg;
               end else begin
                  af_cnt_reg <= af_cnt_reg + 8'd1;
               end
            end
         end

         always_comb begin
            player_byte        = pressed[gi*8 +: 8];
            player_byte[FIRE1] = fire_pressed & (~af_en_reg[gi] | af_on_reg);
         end

         assign cond_word[gi*8 +: 8] = neutralize(player_byte);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         joy1          <= 8'h00;
         joy2          <= 8'h00;
         prev_word_reg <= 16'h0000;
      end else begin
         joy1          <= cond_word[P1_OFS +: 8];
         joy2          <= cond_word[P2_OFS +: 8];
         prev_word_reg <= {joy2, joy1};
      end
   end

   assign change_evt = ({joy2, joy1} != prev_word_reg);

   // Single-entry buffer: a new event always wins over an unaccepted one.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt_valid   <= 1'b0;
         evt_data    <= 16'h0000;
         evt_overrun <= 1'b0;
      end else if (change_evt) begin
         evt_valid <= 1'b1;
         evt_data  <= {joy2, joy1};
         if (evt_valid && !evt_ready) begin
            evt_overrun <= 1'b1;
         end
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_joy_conditioner.sv
// Randomized and directed bench for joy_conditioner against a cycle-level
// behavioural model of the conditioning and event rules.
module tb_joy_conditioner;

   localparam int TD = 16;
   localparam int DB = 4;
   localparam int AF = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] joy_raw_n = 16'hFFFF;
   logic [1:0]  autofire_en = 2'b00;
   logic        evt_ready = 1'b0;
   logic [7:0]  joy1, joy2;
   logic        evt_valid, evt_overrun;
   logic [15:0] evt_data;

   int vectors = 0;
   int miscompares = 0;
   bit started = 0;

   joy_conditioner #(
      .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .AUTOFIRE_TICKS(AF)
   ) dut (
      .clk(clk), .reset(reset), .joy_raw_n(joy_raw_n), .autofire_en(autofire_en),
      .joy1(joy1), .joy2(joy2), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_data(evt_data), .evt_overrun(evt_overrun)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit [15:0] m_s1, m_s2, m_stable;
   int        m_dcnt [16];
   int        m_tcnt;
   int        m_k [2];
   bit [1:0]  m_en;
   bit [7:0]  m_j1, m_j2;
   bit [15:0] m_prev, m_data;
   bit        m_valid, m_ovr;

   function automatic bit [7:0] expect_byte(bit [7:0] pr, bit fire);
      bit [7:0] r;
      r = pr;
      r[3] = fire;
      if (r[7] && r[6]) r[7:6] = 2'b00;
      if (r[5] && r[4]) r[5:4] = 2'b00;
      return r;
   endfunction

   always @(posedge clk) begin : model
      bit [15:0] pr;
      bit [15:0] cur;
      bit        tk;
      bit        fire;
      bit [7:0]  b;
      if (reset) begin
         m_s1 = '1; m_s2 = '1; m_stable = '1;
         for (int i = 0; i < 16; i++) m_dcnt[i] = 0;
         m_tcnt = 0; m_k[0] = 0; m_k[1] = 0; m_en = 0;
         m_j1 = 0; m_j2 = 0; m_prev = 0; m_data = 0; m_valid = 0; m_ovr = 0;
      end else begin
         pr  = ~m_stable;
         cur = {m_j2, m_j1};
         tk  = (m_tcnt == TD - 1);
         m_tcnt = tk ? 0 : m_tcnt + 1;
         if (cur != m_prev) begin
            if (m_valid && !evt_ready) m_ovr = 1;
            m_valid = 1;
            m_data  = cur;
         end else if (m_valid && evt_ready) begin
            m_valid = 0;
         end
         m_prev = cur;
         for (int p = 0; p < 2; p++) begin
            b = pr[p*8 +: 8];
            fire = b[3] && (!m_en[p] || ((m_k[p] / AF) % 2 == 0));
            if (p == 0) m_j1 = expect_byte(b, fire);
            else        m_j2 = expect_byte(b, fire);
            if (!b[3] || !m_en[p]) m_k[p] = 0;
            else if (tk) m_k[p] = m_k[p] + 1;
         end
         if (tk) begin
            for (int i = 0; i < 16; i++) begin
               if (m_s2[i] == m_stable[i]) m_dcnt[i] = 0;
               else begin
                  m_dcnt[i] = m_dcnt[i] + 1;
                  if (m_dcnt[i] == DB) begin
                     m_stable[i] = m_s2[i];
                     m_dcnt[i] = 0;
                  end
               end
            end
            m_en = autofire_en;
         end
         m_s2 = m_s1;
         m_s1 = joy_raw_n;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         vectors++;
         if (joy1 !== m_j1 || joy2 !== m_j2 || evt_valid !== m_valid ||
             evt_data !== m_data || evt_overrun !== m_ovr) begin
            miscompares++;
            $display("FAIL model t=%0t got j1=%h j2=%h v=%b d=%h o=%b expected j1=%h j2=%h v=%b d=%h o=%b",
                     $time, joy1, joy2, evt_valid, evt_data, evt_overrun,
                     m_j1, m_j2, m_valid, m_data, m_ovr);
         end
      end
   end

   always @(posedge clk) begin
      if (!reset && evt_valid && evt_ready)
         $display("evt transfer t=%0t data=%h", $time, evt_data);
   end

   // ---------------- helpers ----------------
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clks(3);
      started = 1;
      reset = 1'b0;
   endtask

   task automatic wait_joy1(input bit [7:0] val, input int budget, input string name);
      for (int i = 0; i < budget && joy1 !== val; i++) @(negedge clk);
      check(name, {8'h00, joy1}, {8'h00, val});
   endtask

   initial begin
      // Press-up latency and single event.
      do_reset();
      joy_raw_n[7] = 1'b0;
      wait_joy1(8'h80, 83, "up_latency");
      clks(1);
      check("up_evt_valid", {15'd0, evt_valid}, 16'h0001);
      check("up_evt_data", evt_data, 16'h0080);
      evt_ready = 1'b1; clks(1); evt_ready = 1'b0;
      clks(20);
      check("up_single_evt", {15'd0, evt_valid}, 16'h0000);

      // Glitch shorter than the debounce window.
      joy_raw_n = 16'hFFFF;
      do_reset();
      joy_raw_n[3] = 1'b0; clks(2 * TD); joy_raw_n[3] = 1'b1;
      clks(100);
      check("glitch_joy1", {8'h00, joy1}, 16'h0000);
      check("glitch_no_evt", {15'd0, evt_valid}, 16'h0000);

      // Opposing directions.
      do_reset();
      joy_raw_n[7] = 1'b0; joy_raw_n[6] = 1'b0;
      clks(100);
      check("updown_neutral", {8'h00, joy1}, 16'h0000);
      check("updown_no_evt", {15'd0, evt_valid}, 16'h0000);
      joy_raw_n[6] = 1'b1;
      wait_joy1(8'h80, 100, "updown_release");

      // Autofire on player 1.
      joy_raw_n = 16'hFFFF;
      do_reset();
      autofire_en = 2'b01;
      joy_raw_n[3] = 1'b0;
      wait_joy1(8'h08, 100, "af_start");
      clks(16); check("af_phase_on", {15'd0, joy1[3]}, 16'h0001);
      clks(32); check("af_phase_off", {15'd0, joy1[3]}, 16'h0000);
      clks(32); check("af_phase_on2", {15'd0, joy1[3]}, 16'h0001);
      joy_raw_n[3] = 1'b1;
      clks(100);
      check("af_release", {8'h00, joy1}, 16'h0000);
      autofire_en = 2'b00;

      // Overrun with ready held low.
      do_reset();
      joy_raw_n[7] = 1'b0;
      wait_joy1(8'h80, 100, "ovr_first");
      joy_raw_n[5] = 1'b0;
      wait_joy1(8'hA0, 100, "ovr_second");
      clks(1);
      check("ovr_data", evt_data, 16'h00A0);
      check("ovr_flag", {15'd0, evt_overrun}, 16'h0001);
      evt_ready = 1'b1; clks(1); evt_ready = 1'b0;
      check("ovr_drop", {15'd0, evt_valid}, 16'h0000);
      check("ovr_sticky", {15'd0, evt_overrun}, 16'h0001);

      // Reset part-way through debounce.
      joy_raw_n = 16'hFFFF;
      do_reset();
      joy_raw_n[7] = 1'b0;
      begin
         int i;
         for (i = 0; i < 100 && m_dcnt[7] != 3; i++) @(negedge clk);
         check("mid_debounce_reached", 16'(i < 100), 16'h0001);
      end
      reset = 1'b1; clks(2);
      check("rst_joy1", {8'h00, joy1}, 16'h0000);
      check("rst_valid", {15'd0, evt_valid}, 16'h0000);
      check("rst_data", evt_data, 16'h0000);
      check("rst_overrun", {15'd0, evt_overrun}, 16'h0000);
      reset = 1'b0;
      clks(50);
      check("rst_no_early", {8'h00, joy1}, 16'h0000);
      wait_joy1(8'h80, 60, "rst_reaccept");
      clks(1);
      check("rst_evt_data", evt_data, 16'h0080);

      // Randomized traffic on both players.
      joy_raw_n = 16'hFFFF;
      do_reset();
      for (int it = 0; it < 45; it++) begin
         int hold;
         joy_raw_n = joy_raw_n ^ (16'(1) << $urandom_range(15, 0)) ^
                     (($urandom % 2 == 0) ? (16'(1) << $urandom_range(15, 0)) : 16'h0000);
         if ($urandom % 4 == 0) autofire_en = 2'($urandom);
         hold = $urandom_range(150, 5);
         for (int c = 0; c < hold; c++) begin
            evt_ready = ($urandom % 3 == 0);
            @(negedge clk);
         end
         if (it == 30) do_reset();
      end
      evt_ready = 1'b0;
      clks(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
